// File: rtl/spi_slave_tx.sv
// spi_slave_tx: mode-0 SPI peripheral transmitter, synchronized SCLK/SS, one-word holding register.
// Define SPI_SLAVE_TRISTATE_EN to release MISO (1'bz) while idle or in reset.
module spi_slave_tx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SCLK,
   input  logic             SS,
   output logic             MISO,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             frame_done,
   output logic             frame_abort,
   output logic             underrun
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync;
   logic sclk_d, ss_d;
   logic [WIDTH-1:0] shift_reg, shift_n, last_word, last_n, holding, holding_n, word;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic ready_n, done_n, abort_n, under_n;
   logic sclk_rise, sclk_fall, ss_fall, ss_rise;
   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
   assign ss_fall   = ~ss_sync[SYNC_STAGES-1] & ss_d;
   assign ss_rise   = ss_sync[SYNC_STAGES-1] & ~ss_d;
   // The frame starts from the held word if one is waiting, otherwise it repeats the last one.
   assign word = ready ? last_word : holding;
   always_comb begin
      state_n   = state;
      shift_n   = shift_reg;
      last_n    = last_word;
      holding_n = holding;
      bit_cnt_n = bit_cnt;
      ready_n   = ready;
      done_n    = 1'b0;
      abort_n   = 1'b0;
      under_n   = 1'b0;
      if (load && ready) begin
         holding_n = data_in;
         ready_n   = 1'b0;
      end
      case (state)
         IDLE:
            if (ss_fall) begin
               state_n   = SHIFT;
               shift_n   = word;
               last_n    = word;
               bit_cnt_n = '0;
               under_n   = ready;
               if (!ready) ready_n = 1'b1;
            end
         SHIFT:
            if (ss_rise) begin
               abort_n = 1'b1;
               state_n = IDLE;
            end else if (sclk_rise) begin
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == CW'(WIDTH - 1)) state_n = DONE;
            end else if (sclk_fall && bit_cnt != '0) begin
               shift_n = {shift_reg[WIDTH-2:0], 1'b0};
            end
         DONE:
            if (ss_rise) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync   <= '0;
         ss_sync     <= '1;
         sclk_d      <= 1'b0;
         ss_d        <= 1'b1;
         state       <= IDLE;
         shift_reg   <= '0;
         last_word   <= '0;
         holding     <= '0;
         bit_cnt     <= '0;
         ready       <= 1'b1;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         ss_sync     <= {ss_sync[SYNC_STAGES-2:0], SS};
         sclk_d      <= sclk_sync[SYNC_STAGES-1];
         ss_d        <= ss_sync[SYNC_STAGES-1];
         state       <= state_n;
         shift_reg   <= shift_n;
         last_word   <= last_n;
         holding     <= holding_n;
         bit_cnt     <= bit_cnt_n;
         ready       <= ready_n;
         frame_done  <= done_n;
         frame_abort <= abort_n;
         underrun    <= under_n;
      end
   end
   // The shift register MSB is the bit currently presented to the master.
`ifdef SPI_SLAVE_TRISTATE_EN
   assign MISO = (reset || state == IDLE) ? 1'bz : shift_reg[WIDTH-1];
`else
   assign MISO = (reset || state == IDLE) ? 1'b0 : shift_reg[WIDTH-1];
`endif
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: directed frames against a word-level model of spi_slave_tx.
module tb_spi_slave_tx;
   localparam int W = 16, S = 2, H = 25;
`ifdef SPI_SLAVE_TRISTATE_EN
   localparam logic IDLE_V = 1'bz;
`else
   localparam logic IDLE_V = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, SCLK = 1'b0, SS = 1'b1, load = 1'b0;
   logic [W-1:0] data_in = '0;
   logic MISO, ready, frame_done, frame_abort, underrun;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int ev_ssf = -1, ev_ssr = -1, ev_load = -1, ev_rst = -1, smp_cyc = -1, smp_idx = 0, m_nrise = 0;
   logic [W-1:0] ld_data = '0, m_hold = '0, m_last = '0, m_cur = '0, rx = '0;
   logic m_full = 1'b0, m_active = 1'b0;

   spi_slave_tx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .SCLK(SCLK), .SS(SS), .MISO(MISO),
      .data_in(data_in), .load(load), .ready(ready),
      .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Word-level model: holding full/empty, last word sent, frame in progress.
   always @(negedge clk) begin : cmp
      logic pre, e_done, e_abort, e_under;
      if (cyc >= 1) begin
         if (cyc == ev_rst) begin
            m_full = 1'b0;
            m_last = '0;
            m_active = 1'b0;
         end
         pre = m_full;
         e_done = 1'b0;
         e_abort = 1'b0;
         e_under = 1'b0;
         if (cyc == ev_ssf) begin
            m_active = 1'b1;
            m_cur = pre ? m_hold : m_last;
            m_last = m_cur;
            e_under = !pre;
            m_full = 1'b0;
         end
         if (cyc == ev_load && !pre) begin
            m_hold = ld_data;
            m_full = 1'b1;
         end
         if (cyc == ev_ssr) begin
            m_active = 1'b0;
            e_done = (m_nrise == W);
            e_abort = !e_done;
         end
         chk("ready", ready, !m_full);
         chk("frame_done", frame_done, e_done);
         chk("frame_abort", frame_abort, e_abort);
         chk("underrun", underrun, e_under);
         if (reset || !m_active) chk("miso_idle", MISO, IDLE_V);
         if (cyc == smp_cyc) chk("miso_bit", MISO, m_cur[W-1-smp_idx]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] d);
      data_in = d;
      ld_data = d;
      load = 1'b1;
      ev_load = cyc + 1;
      tick(1);
      load = 1'b0;
      tick(1);
   endtask

   task automatic frame(input int nrise, input bit rst_mid, input bit ld_sync, input logic [W-1:0] d);
      rx = '0;
      m_nrise = nrise;
      SS = 1'b0;
      ev_ssf = cyc + S + 1;
      tick(2);
      if (ld_sync) begin
         data_in = d;
         ld_data = d;
         load = 1'b1;
         ev_load = cyc + 1;
      end
      tick(1);
      load = 1'b0;
      tick(H - 3);
      for (int i = 0; i < nrise; i++) begin
         if (rst_mid && i == 3) do_load(16'hBEEF);
         rx = {rx[W-2:0], MISO};
         smp_cyc = cyc;
         smp_idx = i;
         SCLK = 1'b1;
         tick(H);
         SCLK = 1'b0;
         tick(i == 7 ? H + 60 : H);
         if (rst_mid && i == 9) begin
            reset = 1'b1;
            SS = 1'b1;
            ev_ssr = -1;
            ev_rst = cyc + 1;
            chk("rst_miso_now", MISO, IDLE_V);
            tick(1);
            chk("rst_ready", ready, 1'b1);
            tick(3);
            reset = 1'b0;
            tick(4);
            return;
         end
      end
      SS = 1'b1;
      ev_ssr = cyc + S + 1;
      tick(H);
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      chk("reset_ready", ready, 1'b1);
      chk("reset_miso", MISO, IDLE_V);
      chk("reset_pulses", {frame_done, frame_abort, underrun}, 3'b000);
      tick(4);
      do_load(16'hA5C3);
      chk("load_ready", ready, 1'b0);
      frame(W, 0, 0, '0);
      chk("rx_first", rx, 16'hA5C3);
      chk("ready_after", ready, 1'b1);
      frame(W, 0, 0, '0);
      chk("rx_repeat", rx, 16'hA5C3);
      frame(5, 0, 0, '0);
      chk("rx_abort", rx, 16'h0014);
      frame(W, 0, 0, '0);
      chk("rx_restart", rx, 16'hA5C3);
      do_load(16'h1234);
      do_load(16'hFFFF);
      chk("ready_ignored", ready, 1'b0);
      frame(W, 0, 0, '0);
      chk("rx_1234", rx, 16'h1234);
      frame(W, 0, 1, 16'h5A5A);
      chk("rx_sync_load", rx, 16'h1234);
      chk("ready_sync_load", ready, 1'b0);
      frame(W, 0, 0, '0);
      chk("rx_5a5a", rx, 16'h5A5A);
      do_load(16'hC0DE);
      frame(W, 1, 0, '0);
      chk("rx_partial", rx, 16'h0303);
      frame(W, 0, 0, '0);
      chk("rx_after_reset", rx, 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
